axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning AXI/SRAM data width; legal values are 32 and 64.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 8, meaning AXI ID width.
REQ-004 SHALL have parameter MEM_AW, default 14, meaning SRAM word-address width.
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port slv, AXI_BUS.Slave modport, parameters equal to the above; aw_prot/aw_lock/aw_cache and the ar_* equivalents are ignored.
REQ-008 SHALL have port mem_req, output, 1 bit, SRAM access strobe.
REQ-009 SHALL have port mem_we, output, 1 bit, 1 for write, 0 for read.
REQ-010 SHALL have port mem_addr, output, MEM_AW bits, SRAM word address.
REQ-011 SHALL have port mem_wdata, output, AXI_DATA_WIDTH bits, write data.
REQ-012 SHALL have port mem_be, output, AXI_DATA_WIDTH/8 bits, byte enables.
REQ-013 SHALL have port mem_rdata, input, AXI_DATA_WIDTH bits, read data valid exactly 1 cycle after a read mem_req.

Function
REQ-014 SHALL implement FSM states IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP; one transaction in flight.
REQ-015 In IDLE: ar_ready=1, aw_ready=!ar_valid (read priority on simultaneous ar_valid/aw_valid); all other states: ar_ready=aw_ready=0.
REQ-016 On handshake SHALL latch id, addr, len, size, burst and clear beat counter; AR -> RD_REQ, AW -> WR_DATA.
REQ-017 Beat address: FIXED (0) unchanged; INCR (1) += 1<<size; WRAP (2) increments, wrapping within the aligned (len+1)<<size-byte block; burst type 3 treated as INCR.
REQ-018 mem_addr SHALL equal beat address >> log2(AXI_DATA_WIDTH/8), truncated to MEM_AW bits.
REQ-019 A beat whose word address is >= 2^MEM_AW SHALL be out-of-range: no mem_req, response SLVERR (2'b10), read data 0.
REQ-020 RD_REQ: mem_req=1, mem_we=0 for one cycle (unless out-of-range) -> RD_DATA.
REQ-021 RD_DATA: mem_rdata captured into r_data on entry cycle; r_valid=1 held, data stable, until r_ready; r_id=latched id, r_resp OKAY (2'b00) or per REQ-019, r_last=1 iff beat==len.
REQ-022 On r handshake: if r_last -> IDLE, else advance address/beat -> RD_REQ; latency AR handshake cycle N -> mem_req N+1 -> r_valid N+2; throughput 1 beat / 2 cycles.
REQ-023 WR_DATA: w_ready=1; on w handshake drive mem_req=1, mem_we=1, mem_wdata=w_data, mem_be=w_strb combinationally in same cycle (suppressed if out-of-range), advance address/beat.
REQ-024 Write burst SHALL end on beat counter == len regardless of w_last -> WR_RESP; w_last mismatch (early, or absent on final beat) SHALL force b_resp SLVERR.
REQ-025 WR_RESP: b_valid=1, b_id=latched id, b_resp OKAY unless any beat errored; hold until b_ready -> IDLE.
REQ-026 b_resp/r_resp SHALL never be EXOKAY or DECERR.
REQ-027 mem_req SHALL be 0 in IDLE and WR_RESP; mem_wdata/mem_be SHALL be 0 when mem_we=0.

Reset
REQ-028 rst_i SHALL asynchronously force IDLE, all valid/ready outputs 0 except per REQ-015 after release, r_data/r_* /b_* 0, counters 0, mem_req 0.
REQ-029 Reset mid-burst SHALL abandon the transaction with no response; first cycle after release in IDLE.

Verification
REQ-030 Single read: AR addr 0x10, len 0, size 3, INCR, id 5, mem word 2 = 0xDEAD -> mem_addr 2 at N+1, r_valid N+2, r_data 0xDEAD, r_last 1, r_id 5, OKAY.
REQ-031 WRAP read: addr 0x18, len 3, size 3 -> mem_addr sequence 3,0,1,2; r_last on 4th beat only; r_ready backpressure 3 cycles holds r_data stable.
REQ-032 INCR write: AW addr 0x0, len 3, w_strb 0x0F, w_last on beat 4 -> 4 mem writes addr 0..3, mem_be 0x0F, then b_valid, b_resp OKAY.
REQ-033 Simultaneous ar_valid and aw_valid in IDLE -> read accepted first, aw_ready 0, write accepted after read's r_last handshake.
REQ-034 Write len 1 with w_last on beat 1 -> 2 beats written, b_resp SLVERR; read at word 2^MEM_AW -> no mem_req, r_resp SLVERR, r_data 0.
REQ-035 rst_i asserted during beat 2 of len-3 read -> r_valid drops immediately, no further mem_req; next AR after release served normally.

Source files
------------

// File: rtl/axi_mem_slave_if.sv
// AXI_BUS: AXI4 bus bundle shared by master and slave ends.
// Carries AW, W, B, AR and R channels.
// Slave modport: request fields and valids in; readys and response fields out.
// Master modport: the mirror image of Slave.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 8
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 slave bridging one burst at a time onto a single-port SRAM.
// Ports:
//   clk_i, rst_i      - rising-edge clock, asynchronous active-high reset
//   slv               - AXI_BUS slave end (prot/lock/cache ignored)
//   mem_req, mem_we   - SRAM strobe and write select
//   mem_addr          - SRAM word address
//   mem_wdata, mem_be - write data and byte enables (zero unless writing)
//   mem_rdata         - read data, valid the cycle after a read strobe
module axi_mem_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 8,
  parameter int unsigned MEM_AW         = 14
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  AXI_BUS.Slave                       slv,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [MEM_AW-1:0]           mem_addr,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_be,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata
);
  localparam int unsigned OFFS = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]                  state_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                  len_q;
  logic [7:0]                  beat_q;
  logic [2:0]                  size_q;
  logic [1:0]                  burst_q;
  logic                        err_q;
  logic                        rfirst_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;

  logic [AXI_ADDR_WIDTH-1:0]   word_addr;
  logic [AXI_ADDR_WIDTH-1:0]   incr;
  logic [AXI_ADDR_WIDTH-1:0]   wrap_mask;
  logic [AXI_ADDR_WIDTH-1:0]   next_addr;
  logic [AXI_DATA_WIDTH-1:0]   rd_word;
  logic                        oor;
  logic                        last_beat;
  logic                        ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic                        wr_strobe;
  logic                        unused_attr;

  assign unused_attr = ^{slv.aw_prot, slv.aw_lock, slv.aw_cache,
                         slv.ar_prot, slv.ar_lock, slv.ar_cache};

  assign word_addr = addr_q >> OFFS;
  assign oor       = (word_addr >> MEM_AW) != '0;
  assign mem_addr  = MEM_AW'(word_addr);
  assign last_beat = (beat_q == len_q);

  // WRAP keeps the upper address bits of the (len+1)<<size block and lets
  // only the in-block offset roll over.
  assign incr      = AXI_ADDR_WIDTH'(1) << size_q;
  assign wrap_mask = ((AXI_ADDR_WIDTH'(len_q) + AXI_ADDR_WIDTH'(1)) << size_q) - AXI_ADDR_WIDTH'(1);

  always_comb begin
    next_addr = addr_q + incr;
    case (burst_q)
      2'd0:    next_addr = addr_q;
      2'd2:    next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: next_addr = addr_q + incr;
    endcase
  end

  // Readys are held low while reset is asserted, not just after release.
  assign slv.ar_ready = (state_q == IDLE) && !rst_i;
  assign slv.aw_ready = (state_q == IDLE) && !rst_i && !slv.ar_valid;
  assign slv.w_ready  = (state_q == WR_DATA);
  assign slv.r_valid  = (state_q == RD_DATA);
  assign slv.b_valid  = (state_q == WR_RESP);

  assign ar_hs = slv.ar_valid && slv.ar_ready;
  assign aw_hs = slv.aw_valid && slv.aw_ready;
  assign w_hs  = slv.w_valid  && slv.w_ready;
  assign r_hs  = slv.r_valid  && slv.r_ready;
  assign b_hs  = slv.b_valid  && slv.b_ready;

  // SRAM data arrives during the first RD_DATA cycle; it is forwarded
  // directly then and served from rdata_q while the master stalls.
  assign rd_word    = oor ? '0 : mem_rdata;
  assign slv.r_data = (slv.r_valid && rfirst_q) ? rd_word : rdata_q;
  assign slv.r_resp = (slv.r_valid && oor) ? RESP_SLVERR : RESP_OKAY;
  assign slv.r_last = slv.r_valid && last_beat;
  assign slv.r_id   = id_q;
  assign slv.b_id   = id_q;
  assign slv.b_resp = (slv.b_valid && err_q) ? RESP_SLVERR : RESP_OKAY;

  assign wr_strobe = w_hs && !oor;
  assign mem_req   = ((state_q == RD_REQ) || w_hs) && !oor;
  assign mem_we    = wr_strobe;
  assign mem_wdata = wr_strobe ? slv.w_data : '0;
  assign mem_be    = wr_strobe ? slv.w_strb : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      rfirst_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            id_q    <= slv.ar_id;
            addr_q  <= slv.ar_addr;
            len_q   <= slv.ar_len;
            size_q  <= slv.ar_size;
            burst_q <= slv.ar_burst;
            beat_q  <= '0;
            state_q <= RD_REQ;
          end else if (aw_hs) begin
            id_q    <= slv.aw_id;
            addr_q  <= slv.aw_addr;
            len_q   <= slv.aw_len;
            size_q  <= slv.aw_size;
            burst_q <= slv.aw_burst;
            beat_q  <= '0;
            err_q   <= 1'b0;
            state_q <= WR_DATA;
          end
        end
        RD_REQ: begin
          rfirst_q <= 1'b1;
          state_q  <= RD_DATA;
        end
        RD_DATA: begin
          rfirst_q <= 1'b0;
          if (rfirst_q) rdata_q <= rd_word;
          if (r_hs) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              addr_q  <= next_addr;
              beat_q  <= beat_q + 8'd1;
              state_q <= RD_REQ;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            // Burst length comes from AW len; w_last only grades the response.
            err_q  <= err_q || oor || (slv.w_last != last_beat);
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 64;
  localparam int unsigned IW    = 4;
  localparam int unsigned MAW   = 6;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned WORDS = 1 << MAW;

  typedef struct { logic [DW-1:0] data; logic [IW-1:0] id; logic [1:0] resp; logic last; } rexp_t;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic we; logic [MAW-1:0] addr; logic [DW-1:0] wdata; logic [NB-1:0] be; } mexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic            mem_req, mem_we;
  logic [MAW-1:0]  mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [NB-1:0]   mem_be;

  logic [DW-1:0] sram    [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] wd [16];
  logic [NB-1:0] ws [16];
  logic          wl [16];

  rexp_t r_q[$];
  bexp_t b_q[$];
  mexp_t m_q[$];

  int vectors = 0;
  int miscompares = 0;
  int rr_hold = 0;
  bit rand_bp = 1'b0;
  bit stall_prev = 1'b0;
  logic [DW-1:0] prev_rdata = '0;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

  axi_mem_slave #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .MEM_AW(MAW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .slv(bus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment SRAM: registered read port, byte-enabled write.
  always @(posedge clk) begin
    if (mem_req && !mem_we) mem_rdata <= sram[mem_addr];
    if (mem_req && mem_we)
      for (int b = 0; b < NB; b++)
        if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference beat address from the burst rules.
  function automatic int unsigned beat_addr(input int unsigned a, input int unsigned len,
                                            input int unsigned sz, input int unsigned bu,
                                            input int unsigned i);
    int unsigned nb, blk, base;
    nb = 1 << sz;
    if (bu == 0) return a;
    if (bu == 2) begin
      blk  = (len + 1) * nb;
      base = (a / blk) * blk;
      return base + ((a - base) + i * nb) % blk;
    end
    return a + i * nb;
  endfunction

  task automatic predict_read(input int unsigned a, input int unsigned len, input int unsigned sz,
                              input int unsigned bu, input logic [IW-1:0] id);
    int unsigned w;
    for (int unsigned i = 0; i <= len; i++) begin
      w = beat_addr(a, len, sz, bu, i) / NB;
      if (w >= WORDS) begin
        r_q.push_back('{data: '0, id: id, resp: 2'b10, last: (i == len)});
      end else begin
        m_q.push_back('{we: 1'b0, addr: MAW'(w), wdata: '0, be: '0});
        r_q.push_back('{data: ref_mem[w], id: id, resp: 2'b00, last: (i == len)});
      end
    end
  endtask

  task automatic predict_write(input int unsigned a, input int unsigned len, input int unsigned sz,
                               input int unsigned bu, input logic [IW-1:0] id);
    int unsigned w;
    bit err;
    err = 1'b0;
    for (int unsigned i = 0; i <= len; i++) begin
      w = beat_addr(a, len, sz, bu, i) / NB;
      if (w >= WORDS) err = 1'b1;
      else begin
        m_q.push_back('{we: 1'b1, addr: MAW'(w), wdata: wd[i], be: ws[i]});
        for (int b = 0; b < NB; b++)
          if (ws[i][b]) ref_mem[w][b*8 +: 8] = wd[i][b*8 +: 8];
      end
      if (wl[i] != (i == len)) err = 1'b1;
    end
    b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
  endtask

  task automatic gen_wdata(input int unsigned len, input bit bad_last, input logic [NB-1:0] fixed_strb,
                           input bit use_fixed);
    int unsigned k;
    for (int unsigned i = 0; i <= len; i++) begin
      wd[i] = {$urandom, $urandom};
      ws[i] = use_fixed ? fixed_strb : NB'($urandom);
      wl[i] = (i == len);
    end
    if (bad_last) begin
      k = $urandom_range(0, len);
      wl[k] = ~wl[k];
    end
  endtask

  task automatic drive_ar(input int unsigned a, input int unsigned len, input int unsigned sz,
                          input int unsigned bu, input logic [IW-1:0] id);
    int guard;
    @(posedge clk); #1;
    bus.ar_addr = AW'(a); bus.ar_len = 8'(len); bus.ar_size = 3'(sz);
    bus.ar_burst = 2'(bu); bus.ar_id = id; bus.ar_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.ar_ready) begin
      guard++;
      if (guard > 500) begin chk("ar_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.ar_valid = 1'b0;
  endtask

  task automatic drive_write(input int unsigned a, input int unsigned len, input int unsigned sz,
                             input int unsigned bu, input logic [IW-1:0] id);
    int guard;
    @(posedge clk); #1;
    bus.aw_addr = AW'(a); bus.aw_len = 8'(len); bus.aw_size = 3'(sz);
    bus.aw_burst = 2'(bu); bus.aw_id = id; bus.aw_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.aw_ready) begin
      guard++;
      if (guard > 500) begin chk("aw_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.aw_valid = 1'b0;
    for (int unsigned i = 0; i <= len; i++) begin
      if (rand_bp && $urandom_range(0, 3) == 0) begin
        bus.w_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.w_valid = 1'b1; bus.w_data = wd[i]; bus.w_strb = ws[i]; bus.w_last = wl[i];
      guard = 0;
      @(negedge clk);
      while (!bus.w_ready) begin
        guard++;
        if (guard > 500) begin chk("w_timeout", 0, 1); break; end
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (r_q.size() != 0 || b_q.size() != 0 || m_q.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk("drain_timeout", 128'(r_q.size() + b_q.size() + m_q.size()), 0);
        r_q.delete(); b_q.delete(); m_q.delete();
        break;
      end
    end
    @(posedge clk);
  endtask

  // Response-channel ready generators.
  initial begin
    bus.r_ready = 1'b0;
    bus.b_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_hold > 0) begin
        bus.r_ready = 1'b0;
        rr_hold--;
      end else begin
        bus.r_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.b_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    rexp_t re;
    bexp_t be;
    mexp_t me;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.r_valid && stall_prev) chk("r_stable", bus.r_data, prev_rdata);
        stall_prev = bus.r_valid && !bus.r_ready;
        prev_rdata = bus.r_data;
        if (bus.r_valid && bus.r_ready) begin
          if (r_q.size() == 0) chk("r_unexpected", 1, 0);
          else begin
            re = r_q.pop_front();
            chk("r_data", bus.r_data, re.data);
            chk("r_id",   bus.r_id,   re.id);
            chk("r_resp", bus.r_resp, re.resp);
            chk("r_last", bus.r_last, re.last);
          end
        end
        if (bus.b_valid && bus.b_ready) begin
          if (b_q.size() == 0) chk("b_unexpected", 1, 0);
          else begin
            be = b_q.pop_front();
            chk("b_id",   bus.b_id,   be.id);
            chk("b_resp", bus.b_resp, be.resp);
          end
        end
        if (mem_req) begin
          if (m_q.size() == 0) chk("mem_unexpected", 1, 0);
          else begin
            me = m_q.pop_front();
            chk("mem_we",   mem_we,   me.we);
            chk("mem_addr", mem_addr, me.addr);
            if (me.we) begin
              chk("mem_wdata", mem_wdata, me.wdata);
              chk("mem_be",    mem_be,    me.be);
            end else begin
              chk("mem_rd_quiet", {mem_wdata, mem_be}, '0);
            end
          end
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin
    int seen, guard;
    int unsigned a, len, sz, bu;
    logic [IW-1:0] id;
    bit is_wr;

    bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0;
    bus.aw_burst = '0; bus.aw_lock = '0; bus.aw_cache = '0; bus.aw_prot = '0;
    bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0;
    bus.ar_burst = '0; bus.ar_lock = '0; bus.ar_cache = '0; bus.ar_prot = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
    for (int i = 0; i < WORDS; i++) begin
      sram[i] = {$urandom, $urandom};
      ref_mem[i] = sram[i];
    end
    sram[2] = 64'hDEAD; ref_mem[2] = 64'hDEAD;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ar_ready", bus.ar_ready, 0);
    chk("rst_aw_ready", bus.aw_ready, 0);
    chk("rst_valids",   {bus.r_valid, bus.b_valid, bus.w_ready, mem_req}, 0);
    chk("rst_outputs",  {bus.r_data, bus.r_last, bus.r_resp, bus.b_resp}, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_ar_ready", bus.ar_ready, 1);
    chk("idle_aw_ready", bus.aw_ready, 1);

    // Single read with latency check.
    predict_read(32'h10, 0, 3, 1, 4'h5);
    drive_ar(32'h10, 0, 3, 1, 4'h5);
    @(negedge clk);
    chk("lat_mem_req",  {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 6'd2});
    @(negedge clk);
    chk("lat_r_valid",  bus.r_valid, 1);
    wait_idle();

    // WRAP read with a stalled first beat.
    predict_read(32'h18, 3, 3, 2, 4'h3);
    drive_ar(32'h18, 3, 3, 2, 4'h3);
    @(negedge clk); rr_hold = 4;
    wait_idle();

    // INCR write, strobe 0x0F.
    gen_wdata(3, 1'b0, 8'h0F, 1'b1);
    predict_write(0, 3, 3, 1, 4'h7);
    drive_write(0, 3, 3, 1, 4'h7);
    wait_idle();

    // Simultaneous AR and AW: read wins.
    gen_wdata(1, 1'b0, 8'hFF, 1'b1);
    predict_read(32'h40, 1, 3, 1, 4'h1);
    predict_write(32'h40, 1, 3, 1, 4'h2);
    fork
      drive_ar(32'h40, 1, 3, 1, 4'h1);
      drive_write(32'h40, 1, 3, 1, 4'h2);
      begin
        @(posedge clk); @(negedge clk);
        chk("aw_blocked", {bus.ar_valid, bus.aw_valid, bus.aw_ready}, 3'b110);
      end
    join
    wait_idle();

    // Early w_last on a len-1 write.
    gen_wdata(1, 1'b0, 8'hFF, 1'b1);
    wl[0] = 1'b1; wl[1] = 1'b0;
    predict_write(32'h80, 1, 3, 1, 4'h9);
    drive_write(32'h80, 1, 3, 1, 4'h9);
    wait_idle();

    // Read just past the top of the SRAM.
    predict_read(WORDS * NB, 0, 3, 1, 4'hA);
    drive_ar(WORDS * NB, 0, 3, 1, 4'hA);
    wait_idle();

    // Reset during beat 2 of a len-3 read.
    predict_read(32'h20, 3, 3, 1, 4'h6);
    drive_ar(32'h20, 3, 3, 1, 4'h6);
    seen = 0; guard = 0;
    while (seen < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (bus.r_valid) seen++;
    end
    chk("rst_mid_reached", seen, 2);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", {bus.r_valid, mem_req}, 0);
    r_q.delete(); m_q.delete(); b_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_quiet", {bus.r_valid, mem_req, bus.ar_ready}, 0);
    end
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_idle", {bus.ar_ready, bus.r_valid, mem_req}, 3'b100);
    predict_read(32'h28, 1, 3, 1, 4'hC);
    drive_ar(32'h28, 1, 3, 1, 4'hC);
    wait_idle();

    // Randomized traffic with backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sz = $urandom_range(0, 3);
      bu = $urandom_range(0, 3);
      len = (bu == 2) ? (1 << $urandom_range(1, 3)) - 1 : $urandom_range(0, 7);
      a  = $urandom_range(0, 16'h23F) & ~((1 << sz) - 1);
      id = IW'($urandom);
      is_wr = 1'($urandom_range(0, 1));
      if (is_wr) begin
        gen_wdata(len, $urandom_range(0, 7) == 0, '0, 1'b0);
        predict_write(a, len, sz, bu, id);
        drive_write(a, len, sz, bu, id);
      end else begin
        predict_read(a, len, sz, bu, id);
        drive_ar(a, len, sz, bu, id);
      end
      wait_idle();
    end

    chk("end_queues", 128'(r_q.size() + b_q.size() + m_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
